aes_mixw: RTL and testbench
===========================

AES_MIXW -- requirements
Module: aes_mixw

Interface
REQ-001 The module SHALL have no parameters.
REQ-002 clk_i  input  1  system clock; the module SHALL use one clock only; all registers SHALL update on its rising edge.
REQ-003 rst_i  input  1  reset; the module SHALL treat it as synchronous and active-high.
REQ-004 w_i  input  32  one AES state column; byte k SHALL be w_i[8k+7:8k], so byte 0 = w_i[7:0] (row 0) and byte 3 = w_i[31:24] (row 3).
REQ-005 mixw_o  output  32  combinational forward MixColumns of w_i, using the same byte order as w_i.
REQ-006 imixw_o  output  32  combinational inverse MixColumns of w_i, using the same byte order.
REQ-007 mixw_q_o  output  32  registered copy of mixw_o.
REQ-008 imixw_q_o  output  32  registered copy of imixw_o.

Function
REQ-009 Arithmetic SHALL be in GF(2^8) with reduction polynomial x^8+x^4+x^3+x+1 (0x11B).
REQ-010 xtime(a) SHALL equal (a<<1) XOR (0x1B if a[7]=1), truncated to 8 bits.
REQ-011 Forward mix, with input bytes b0..b3 and output bytes o0..o3, SHALL be:
  - o0 = 2·b0 ^ 3·b1 ^ b2 ^ b3
  - o1 = b0 ^ 2·b1 ^ 3·b2 ^ b3
  - o2 = b0 ^ b1 ^ 2·b2 ^ 3·b3
  - o3 = 3·b0 ^ b1 ^ b2 ^ 2·b3
REQ-012 Inverse mix SHALL be:
  - o0 = 14·b0 ^ 11·b1 ^ 13·b2 ^ 9·b3
  - o1 = 9·b0 ^ 14·b1 ^ 11·b2 ^ 13·b3
  - o2 = 13·b0 ^ 9·b1 ^ 14·b2 ^ 11·b3
  - o3 = 11·b0 ^ 13·b1 ^ 9·b2 ^ 14·b3
REQ-013 The constant multiplies (2, 3, 9, 11, 13, 14) SHALL be built from xtime/XOR chains only, with no lookup tables and no general multiplier.
REQ-014 mixw_o and imixw_o SHALL depend only on w_i; they SHALL have zero clock latency and SHALL NOT depend on clk_i or rst_i.
REQ-015 Outputs SHALL be valid within 1 ns of a w_i change in zero-delay simulation, with no latches.
REQ-016 mixw_q_o and imixw_q_o SHALL have 1-cycle latency: at each rising edge with rst_i=0 they SHALL load the current mixw_o and imixw_o.
REQ-017 There SHALL be no handshake and no state machine; a new w_i is accepted every cycle.
REQ-018 For any w_i, the inverse of the forward result SHALL equal w_i, and the forward of the inverse result SHALL equal w_i.
REQ-019 Fixed points: w_i=0x00000000 SHALL give 0x00000000 on both combinational outputs.
REQ-020 If all four input bytes are equal to x, both combinational outputs SHALL equal {x,x,x,x}.
REQ-021 If w_i is X or Z, the combinational outputs are unspecified, but the registered outputs SHALL still reset correctly.

Reset
REQ-022 When rst_i=1 at a rising edge, mixw_q_o and imixw_q_o SHALL become 0x00000000 at that edge.
REQ-023 Reset SHALL have priority over loading the registers.
REQ-024 Reset SHALL NOT affect mixw_o or imixw_o.
REQ-025 If reset is asserted mid-stream, the first valid registered result SHALL appear on the first rising edge after rst_i returns to 0.

Verification
REQ-026 Forward vectors: drive w_i, wait 1 ns, then check mixw_o:
  - 0x1a96de77 -> 0xe5b06b1b
  - 0xe598271e -> 0x4c260628
  - 0x3b87db49 -> 0xf1ca4d58
  - 0x305dbfd4 -> 0xe5816604
REQ-027 Inverse vectors: drive w_i, then check imixw_o:
  - 0xe5b06b1b -> 0x1a96de77
  - 0x4c260628 -> 0xe598271e
  - 0xf1ca4d58 -> 0x3b87db49
  - 0xe5816604 -> 0x305dbfd4
REQ-028 Degenerate inputs:
  - 0x00000000 -> mixw_o = imixw_o = 0x00000000
  - 0x01010101 -> mixw_o = imixw_o = 0x01010101
  - 0xffffffff -> mixw_o = imixw_o = 0xffffffff
REQ-029 Registered path: with rst_i=0, drive w_i=0x1a96de77 before edge N; after edge N, mixw_q_o=0xe5b06b1b and imixw_q_o=imixw_o of that input.
REQ-030 Reset: rst_i=1 for one edge while w_i=0x1a96de77 -> mixw_q_o=imixw_q_o=0x00000000 while mixw_o stays 0xe5b06b1b; after rst_i=0, the next edge loads 0xe5b06b1b.
REQ-031 Random round-trip: for at least 1000 random w_i, applying inverse to mixw_o and forward to imixw_o SHALL both return w_i.

Source files
------------

// File: rtl/aes_mixw.sv
// AES MixColumns / InvMixColumns on one state column.
// Combinational outputs plus a registered copy of each.
module aes_mixw (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] w_i,
    output logic [31:0] mixw_o,
    output logic [31:0] imixw_o,
    output logic [31:0] mixw_q_o,
    output logic [31:0] imixw_q_o
);

    function automatic logic [7:0] xt(
        input logic [7:0] a
    );
        return {a[6:0], 1'b0}
             ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(
        input logic [7:0] a
    );
        return xt(a) ^ a;
    endfunction

    function automatic logic [7:0] mul9(
        input logic [7:0] a
    );
        return xt(xt(xt(a))) ^ a;
    endfunction

    function automatic logic [7:0] mul11(
        input logic [7:0] a
    );
        logic [7:0] x2;
        x2 = xt(a);
        return xt(xt(x2)) ^ x2 ^ a;
    endfunction

    function automatic logic [7:0] mul13(
        input logic [7:0] a
    );
        logic [7:0] x4;
        x4 = xt(xt(a));
        return xt(x4) ^ x4 ^ a;
    endfunction

    function automatic logic [7:0] mul14(
        input logic [7:0] a
    );
        logic [7:0] x2;
        logic [7:0] x4;
        x2 = xt(a);
        x4 = xt(x2);
        return xt(x4) ^ x4 ^ x2;
    endfunction

    // Each output row is the row-0 equation rotated by its index.
    for (genvar k = 0; k < 4; k++) begin : g_row
        localparam int K1 = (k + 1) % 4;
        localparam int K2 = (k + 2) % 4;
        localparam int K3 = (k + 3) % 4;

        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;

        assign b0 = w_i[8*k  +: 8];
        assign b1 = w_i[8*K1 +: 8];
        assign b2 = w_i[8*K2 +: 8];
        assign b3 = w_i[8*K3 +: 8];

        assign mixw_o[8*k +: 8] =
            xt(b0) ^ mul3(b1) ^ b2 ^ b3;

        assign imixw_o[8*k +: 8] =
            mul14(b0) ^ mul11(b1)
          ^ mul13(b2) ^ mul9(b3);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mixw_q_o  <= 32'h0;
            imixw_q_o <= 32'h0;
        end else begin
            mixw_q_o  <= mixw_o;
            imixw_q_o <= imixw_o;
        end
    end

endmodule

// File: tb/tb_aes_mixw.sv
// Self-checking bench for aes_mixw.
// Reference model: generic GF(2^8) matrix product.
module tb_aes_mixw;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] w_i;
    logic [31:0] mixw_o;
    logic [31:0] imixw_o;
    logic [31:0] mixw_q_o;
    logic [31:0] imixw_q_o;

    int n_chk;
    int n_fail;

    aes_mixw dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .w_i       (w_i),
        .mixw_o    (mixw_o),
        .imixw_o   (imixw_o),
        .mixw_q_o  (mixw_q_o),
        .imixw_q_o (imixw_q_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Shift-and-add multiply modulo 0x11B.
    function automatic int gmul(
        input int a,
        input int b
    );
        int p;
        int x;
        p = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if ((b >> i) & 1) p = p ^ x;
            x = x << 1;
            if (x & 32'h100) x = x ^ 32'h11b;
        end
        return p & 8'hff;
    endfunction

    // Circulant matrix: entry (r,c) = cf[(c-r) mod 4].
    function automatic logic [31:0] mat(
        input logic [31:0] w,
        input bit          inv
    );
        int cf [4];
        int acc;
        logic [31:0] r;
        if (inv) cf = '{14, 11, 13, 9};
        else     cf = '{2, 3, 1, 1};
        r = '0;
        for (int row = 0; row < 4; row++) begin
            acc = 0;
            for (int c = 0; c < 4; c++)
                acc = acc ^ gmul(
                    int'(w[8*c +: 8]),
                    cf[(c - row + 4) % 4]);
            r[8*row +: 8] = acc[7:0];
        end
        return r;
    endfunction

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h",
                     tag, got, exp);
        end
    endtask

    logic [31:0] fv_in  [4];
    logic [31:0] fv_out [4];
    logic [31:0] dg     [3];
    logic [31:0] rw;
    logic [31:0] t;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        fv_in  = '{32'h1a96de77, 32'he598271e,
                   32'h3b87db49, 32'h305dbfd4};
        fv_out = '{32'he5b06b1b, 32'h4c260628,
                   32'hf1ca4d58, 32'he5816604};
        dg     = '{32'h00000000, 32'h01010101,
                   32'hffffffff};

        rst_i = 1'b1;
        w_i   = 32'h1234_5678;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_mixq",  mixw_q_o,  32'h0);
        chk("rst_imixq", imixw_q_o, 32'h0);
        chk("rst_comb",  mixw_o,
            mat(32'h1234_5678, 1'b0));

        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 4; i++) begin
            w_i = fv_in[i];
            #1;
            chk("fwd_vec", mixw_o, fv_out[i]);
            chk("fwd_mdl", mixw_o,
                mat(fv_in[i], 1'b0));
            w_i = fv_out[i];
            #1;
            chk("inv_vec", imixw_o, fv_in[i]);
            chk("inv_mdl", imixw_o,
                mat(fv_out[i], 1'b1));
        end

        for (int i = 0; i < 3; i++) begin
            w_i = dg[i];
            #1;
            chk("dg_fwd", mixw_o,  dg[i]);
            chk("dg_inv", imixw_o, dg[i]);
        end

        @(negedge clk_i);
        w_i = 32'h1a96de77;
        @(posedge clk_i);
        #1;
        chk("reg_mix",  mixw_q_o, 32'he5b06b1b);
        chk("reg_imix", imixw_q_o,
            mat(32'h1a96de77, 1'b1));

        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("mid_rst_mq", mixw_q_o,  32'h0);
        chk("mid_rst_iq", imixw_q_o, 32'h0);
        chk("mid_rst_c",  mixw_o, 32'he5b06b1b);
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("pre_load", mixw_q_o, 32'h0);
        @(posedge clk_i);
        #1;
        chk("post_rst", mixw_q_o, 32'he5b06b1b);

        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_i);
            rw  = $urandom;
            w_i = rw;
            #1;
            chk("rnd_fwd", mixw_o,  mat(rw, 1'b0));
            chk("rnd_inv", imixw_o, mat(rw, 1'b1));
            t   = mixw_o;
            w_i = t;
            #1;
            chk("rt_fi", imixw_o, rw);
            w_i = rw;
            #1;
            t   = imixw_o;
            w_i = t;
            #1;
            chk("rt_if", mixw_o, rw);
            w_i = rw;
            @(posedge clk_i);
            #1;
            chk("rnd_mq", mixw_q_o,  mat(rw, 1'b0));
            chk("rnd_iq", imixw_q_o, mat(rw, 1'b1));
        end

        $display(
          "End of test - %0d assertions evaluated, %0d failures",
          n_chk, n_fail);
        $finish;
    end

endmodule
